// File: rtl/mips_run_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_controller_if
//  Description : Bus bundle between the run controller, the spare read port of
//                the dual-port data memory and the dump-word consumer.
//                  mem_rd_addr  controller -> memory   word index to read
//                  mem_rd_data  memory -> controller   read data
//                  dump_valid   controller -> consumer word available
//                  dump_ready   consumer -> controller word accepted
//                  dump_addr    controller -> consumer index of current word
//                  dump_data    controller -> consumer current word
//                The controller uses the master modport. The memory and the
//                consumer together form the slave side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_run_controller_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [N-1:0]      mem_rd_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_addr;
   logic [N-1:0]      dump_data;

   modport master (
      output mem_rd_addr,
      input  mem_rd_data,
      output dump_valid,
      input  dump_ready,
      output dump_addr,
      output dump_data
   );

   modport slave (
      input  mem_rd_addr,
      output mem_rd_data,
      input  dump_valid,
      output dump_ready,
      input  dump_addr,
      input  dump_data
   );
endinterface
`default_nettype wire

// File: rtl/mips_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_controller
//  Description : Run and dump sequencer for the multicycle MIPS core. On start
//                it holds the core in reset for RESET_CYCLES cycles. It then
//                enables the core for a cycle budget, or until halt_req. After
//                that it streams a window of data-memory words out over a
//                valid/ready port.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                start               one-cycle pulse, honoured in IDLE/DONE
//                num_cycles          run budget (0 selects MAX_CYCLES)
//                dump_start/stop     dump window [start, stop)
//                halt_req            early stop request during RUN
//                core_rst/core_run   reset and clock-enable to the core
//                cycle_count         run cycles elapsed
//                done, halted_early  sequence status
//                bus (master)        memory read port + dump stream
//  Revision    : 1.0  initial release
// ============================================================================
module mips_run_controller #(
   parameter int N            = 32,
   parameter int ADDR_W       = 32,
   parameter int CYC_W        = 32,
   parameter int RESET_CYCLES = 2,
   parameter int MAX_CYCLES   = 1000,
   parameter int MEM_LAT      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CYC_W-1:0]  num_cycles,
   input  logic [ADDR_W-1:0] dump_start,
   input  logic [ADDR_W-1:0] dump_stop,
   input  logic              halt_req,
   output logic              core_rst,
   output logic              core_run,
   output logic [CYC_W-1:0]  cycle_count,
   output logic              done,
   output logic              halted_early,
   mips_run_controller_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RESET     = 3'd1,
      ST_RUN       = 3'd2,
      ST_DUMP_ADDR = 3'd3,
      ST_DUMP_WAIT = 3'd4,
      ST_DUMP_OUT  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   localparam logic [CYC_W-1:0] MAX_BUDGET = CYC_W'(MAX_CYCLES);
   // Value of the reset counter on the last cycle spent in ST_RESET.
   localparam logic [31:0] RST_LAST = (RESET_CYCLES > 0) ? 32'(RESET_CYCLES - 1) : 32'd0;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
   logic [CYC_W-1:0]  budget_q, budget_d;
   logic [ADDR_W-1:0] win_start_q, win_start_d;
   logic [ADDR_W-1:0] win_stop_q, win_stop_d;
   logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
   logic [N-1:0]      dump_data_q, dump_data_d;
   logic              halted_q, halted_d;
   logic [31:0]       rst_cnt_q, rst_cnt_d;

   logic [CYC_W-1:0]  count_inc;
   logic [ADDR_W-1:0] addr_inc;

   assign count_inc = cycle_count_q + CYC_W'(1);
   assign addr_inc  = dump_addr_q + ADDR_W'(1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cycle_count_q <= '0;
         budget_q      <= '0;
         win_start_q   <= '0;
         win_stop_q    <= '0;
         dump_addr_q   <= '0;
         dump_data_q   <= '0;
         halted_q      <= 1'b0;
         rst_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cycle_count_q <= cycle_count_d;
         budget_q      <= budget_d;
         win_start_q   <= win_start_d;
         win_stop_q    <= win_stop_d;
         dump_addr_q   <= dump_addr_d;
         dump_data_q   <= dump_data_d;
         halted_q      <= halted_d;
         rst_cnt_q     <= rst_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cycle_count_d = cycle_count_q;
      budget_d      = budget_q;
      win_start_d   = win_start_q;
      win_stop_d    = win_stop_q;
      dump_addr_d   = dump_addr_q;
      dump_data_d   = dump_data_q;
      halted_d      = halted_q;
      rst_cnt_d     = rst_cnt_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               budget_d      = (num_cycles == '0) ? MAX_BUDGET : num_cycles;
               win_start_d   = dump_start;
               win_stop_d    = dump_stop;
               halted_d      = 1'b0;
               cycle_count_d = '0;
               rst_cnt_d     = '0;
               // With no reset hold the core starts running on the very
               // next cycle.
               state_d       = (RESET_CYCLES == 0) ? ST_RUN : ST_RESET;
            end
         end

         ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = ST_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + 32'd1;
            end
         end

         ST_RUN: begin
            // The cycle that sees halt_req still counts as a run cycle.
            cycle_count_d = count_inc;
            if (halt_req || (count_inc == budget_q)) begin
               halted_d = halt_req && (count_inc < budget_q);
               // The window is exclusive of dump_stop. An empty or inverted
               // window produces no words.
               if (win_stop_q <= win_start_q) begin
                  state_d = ST_DONE;
               end else begin
                  dump_addr_d = win_start_q;
                  state_d     = ST_DUMP_ADDR;
               end
            end
         end

         ST_DUMP_ADDR: begin
            if (MEM_LAT == 0) begin
               // Asynchronous read port: data is valid in the address cycle.
               dump_data_d = bus.mem_rd_data;
               state_d     = ST_DUMP_OUT;
            end else begin
               state_d = ST_DUMP_WAIT;
            end
         end

         ST_DUMP_WAIT: begin
            dump_data_d = bus.mem_rd_data;
            state_d     = ST_DUMP_OUT;
         end

         ST_DUMP_OUT: begin
            if (bus.dump_ready) begin
               if (addr_inc == win_stop_q) begin
                  state_d = ST_DONE;
               end else begin
                  dump_addr_d = addr_inc;
                  state_d     = ST_DUMP_ADDR;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs decoded from registered state
   // ------------------------------------------------------------------------
   // The core stays in reset only while idle after rst or during the hold. Once
   // a run has ended it is frozen (no reset, no enable), so its state can be
   // inspected.
   assign core_rst     = (state_q == ST_IDLE) || (state_q == ST_RESET);
   assign core_run     = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign cycle_count  = cycle_count_q;
   assign halted_early = halted_q;

   // The memory port follows the current dump index. The index is stable
   // from DUMP_ADDR onward, so it is valid in the cycle the memory samples it.
   assign bus.mem_rd_addr = dump_addr_q;
   assign bus.dump_valid  = (state_q == ST_DUMP_OUT);
   assign bus.dump_addr   = dump_addr_q;
   assign bus.dump_data   = dump_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_run_controller
//  Description : Self-checking bench for mips_run_controller. Two instances:
//                u_dut1 (MEM_LAT=1, RESET_CYCLES=2, synchronous memory) and
//                u_dut0 (MEM_LAT=0, RESET_CYCLES=0, asynchronous memory).
//                Both share the stimulus; sel picks the observed instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_run_controller;
   localparam int N      = 32;
   localparam int ADDR_W = 32;
   localparam int CYC_W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              halt_req;
   logic              dump_ready;
   logic [CYC_W-1:0]  num_cycles;
   logic [ADDR_W-1:0] dump_start;
   logic [ADDR_W-1:0] dump_stop;

   logic              core_rst1, core_run1, done1, halted1;
   logic              core_rst0, core_run0, done0, halted0;
   logic [CYC_W-1:0]  cc1, cc0;

   logic [N-1:0]      mem [0:63];

   mips_run_controller_if #(.N(N), .ADDR_W(ADDR_W)) bus1 ();
   mips_run_controller_if #(.N(N), .ADDR_W(ADDR_W)) bus0 ();

   always #5 clk = ~clk;

   assign bus1.dump_ready = dump_ready;
   assign bus0.dump_ready = dump_ready;
   always @(posedge clk) bus1.mem_rd_data <= mem[bus1.mem_rd_addr[5:0]];
   assign bus0.mem_rd_data = mem[bus0.mem_rd_addr[5:0]];

   mips_run_controller #(
      .N(N), .ADDR_W(ADDR_W), .CYC_W(CYC_W),
      .RESET_CYCLES(2), .MAX_CYCLES(1000), .MEM_LAT(1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
      .dump_start(dump_start), .dump_stop(dump_stop), .halt_req(halt_req),
      .core_rst(core_rst1), .core_run(core_run1), .cycle_count(cc1),
      .done(done1), .halted_early(halted1), .bus(bus1)
   );

   mips_run_controller #(
      .N(N), .ADDR_W(ADDR_W), .CYC_W(CYC_W),
      .RESET_CYCLES(0), .MAX_CYCLES(1000), .MEM_LAT(0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
      .dump_start(dump_start), .dump_stop(dump_stop), .halt_req(halt_req),
      .core_rst(core_rst0), .core_run(core_run0), .cycle_count(cc0),
      .done(done0), .halted_early(halted0), .bus(bus0)
   );

   // Observed instance
   logic              sel;
   logic              o_core_rst, o_core_run, o_done, o_halted, o_valid;
   logic [CYC_W-1:0]  o_cc;
   logic [ADDR_W-1:0] o_addr, o_mem_addr;
   logic [N-1:0]      o_data;
   assign o_core_rst = sel ? core_rst0 : core_rst1;
   assign o_core_run = sel ? core_run0 : core_run1;
   assign o_done     = sel ? done0 : done1;
   assign o_halted   = sel ? halted0 : halted1;
   assign o_cc       = sel ? cc0 : cc1;
   assign o_valid    = sel ? bus0.dump_valid : bus1.dump_valid;
   assign o_addr     = sel ? bus0.dump_addr : bus1.dump_addr;
   assign o_mem_addr = sel ? bus0.mem_rd_addr : bus1.mem_rd_addr;
   assign o_data     = sel ? bus0.dump_data : bus1.dump_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Scoreboard: expected words pushed at start, observed words pushed on handshake
   logic [ADDR_W-1:0] exp_addr[$];
   logic [N-1:0]      exp_data[$];
   logic [ADDR_W-1:0] got_addr[$];
   logic [N-1:0]      got_data[$];

   // Per-run observations
   int rst_cyc, run_cyc, valid_cyc, unstable, last_run_c, done_c, hs_first, hs_last;
   logic timed_out;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; halt_req = 1'b0; dump_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic clear_q();
      exp_addr.delete(); exp_data.delete(); got_addr.delete(); got_data.delete();
   endtask

   task automatic start_seq(input logic [CYC_W-1:0] nc, input int ds, input int de);
      num_cycles = nc; dump_start = ADDR_W'(ds); dump_stop = ADDR_W'(de);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int a = ds; a < de; a++) begin
         exp_addr.push_back(ADDR_W'(a));
         exp_data.push_back(mem[a[5:0]]);
      end
   endtask

   // Drives halt_req/dump_ready and records what the observed DUT does until done.
   task automatic run_seq(input int limit, input int stall, input int halt_at);
      int wait_cnt;
      logic held;
      logic [ADDR_W-1:0] h_addr;
      logic [N-1:0] h_data;
      rst_cyc = 0; run_cyc = 0; valid_cyc = 0; unstable = 0;
      last_run_c = -1; done_c = -1; hs_first = -1; hs_last = -1;
      timed_out = 1'b1; wait_cnt = 0; held = 1'b0; h_addr = '0; h_data = '0;
      for (int c = 0; c < limit; c++) begin
         halt_req = 1'b0;
         if (o_done) begin
            done_c = c; timed_out = 1'b0;
            break;
         end
         if (o_core_rst) rst_cyc++;
         if (o_core_run) begin
            run_cyc++; last_run_c = c;
            if (run_cyc == halt_at) halt_req = 1'b1;
         end
         if (o_valid) begin
            valid_cyc++;
            if (held && ((o_addr !== h_addr) || (o_data !== h_data))) unstable++;
            dump_ready = (wait_cnt >= stall);
            if (dump_ready) begin
               got_addr.push_back(o_addr); got_data.push_back(o_data);
               if (hs_first < 0) hs_first = c;
               hs_last = c; held = 1'b0; wait_cnt = 0;
            end else begin
               held = 1'b1; h_addr = o_addr; h_data = o_data; wait_cnt++;
            end
         end else begin
            dump_ready = (stall == 0);
         end
         tick();
      end
      halt_req = 1'b0;
      dump_ready = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         do_reset();
         rst = 1'b1;
         tick();
         n_cmp++;
         if ({o_core_rst, o_core_run, o_valid, o_done, o_halted} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl[%0d]: got %b expected 10000", s,
                     {o_core_rst, o_core_run, o_valid, o_done, o_halted});
         end
         n_cmp++;
         if ({o_cc, o_mem_addr, o_addr, o_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data[%0d]: cc=%0d mem_addr=%0d addr=%0d data=%h expected all 0",
                     s, o_cc, o_mem_addr, o_addr, o_data);
         end
         rst = 1'b0;
      end
   endtask

   task automatic test_nominal();
      sel = 1'b0; do_reset(); clear_q();
      start_seq(5, 4, 14);
      run_seq(300, 0, 0);
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL nom_timeout: got %0b expected 0", timed_out); end
      n_cmp++; if (rst_cyc != 2) begin n_bad++; $display("FAIL nom_rst_cycles: got %0d expected 2", rst_cyc); end
      n_cmp++; if (run_cyc != 5) begin n_bad++; $display("FAIL nom_run_cycles: got %0d expected 5", run_cyc); end
      n_cmp++; if (o_cc !== 32'd5) begin n_bad++; $display("FAIL nom_cycle_count: got %0d expected 5", o_cc); end
      n_cmp++; if (got_addr.size() != 10) begin n_bad++; $display("FAIL nom_words: got %0d expected 10", got_addr.size()); end
      n_cmp++; if (hs_last - hs_first != 27) begin n_bad++; $display("FAIL nom_throughput: got %0d expected 27", hs_last - hs_first); end
      while (exp_addr.size() > 0 && got_addr.size() > 0) begin
         logic [ADDR_W-1:0] ea, ga; logic [N-1:0] ed, gd;
         ea = exp_addr.pop_front(); ed = exp_data.pop_front();
         ga = got_addr.pop_front(); gd = got_data.pop_front();
         n_cmp++;
         if ({ga, gd} !== {ea, ed}) begin
            n_bad++; $display("FAIL nom_word: got %0d/%h expected %0d/%h", ga, gd, ea, ed);
         end
      end
      n_cmp++; if ({o_done, o_halted} !== 2'b10) begin n_bad++; $display("FAIL nom_status: got %b expected 10", {o_done, o_halted}); end
   endtask

   task automatic test_early_halt();
      sel = 1'b0; do_reset(); clear_q();
      start_seq(100, 0, 2);
      run_seq(300, 0, 7);
      n_cmp++; if (run_cyc != 7) begin n_bad++; $display("FAIL halt7_run_cycles: got %0d expected 7", run_cyc); end
      n_cmp++; if (o_cc !== 32'd7) begin n_bad++; $display("FAIL halt7_cycle_count: got %0d expected 7", o_cc); end
      n_cmp++; if ({o_done, o_halted} !== 2'b11) begin n_bad++; $display("FAIL halt7_status: got %b expected 11", {o_done, o_halted}); end
      n_cmp++; if (got_addr.size() != 2) begin n_bad++; $display("FAIL halt7_words: got %0d expected 2", got_addr.size()); end
      while (exp_addr.size() > 0 && got_addr.size() > 0) begin
         logic [ADDR_W-1:0] ea, ga; logic [N-1:0] ed, gd;
         ea = exp_addr.pop_front(); ed = exp_data.pop_front();
         ga = got_addr.pop_front(); gd = got_data.pop_front();
         n_cmp++;
         if ({ga, gd} !== {ea, ed}) begin
            n_bad++; $display("FAIL halt7_word: got %0d/%h expected %0d/%h", ga, gd, ea, ed);
         end
      end
      clear_q();
      // halt_req on the very cycle the budget is reached is not an early halt
      start_seq(100, 3, 4);
      run_seq(400, 0, 100);
      n_cmp++; if (run_cyc != 100) begin n_bad++; $display("FAIL halt100_run_cycles: got %0d expected 100", run_cyc); end
      n_cmp++; if (o_cc !== 32'd100) begin n_bad++; $display("FAIL halt100_cycle_count: got %0d expected 100", o_cc); end
      n_cmp++; if ({o_done, o_halted} !== 2'b10) begin n_bad++; $display("FAIL halt100_status: got %b expected 10", {o_done, o_halted}); end
      clear_q();
   endtask

   task automatic test_default_budget();
      sel = 1'b0; do_reset(); clear_q();
      start_seq(0, 8, 8);
      run_seq(1300, 0, 0);
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL dflt_timeout: got %0b expected 0", timed_out); end
      n_cmp++; if (run_cyc != 1000) begin n_bad++; $display("FAIL dflt_run_cycles: got %0d expected 1000", run_cyc); end
      n_cmp++; if (o_cc !== 32'd1000) begin n_bad++; $display("FAIL dflt_cycle_count: got %0d expected 1000", o_cc); end
      n_cmp++; if (valid_cyc != 0) begin n_bad++; $display("FAIL dflt_valid: got %0d expected 0", valid_cyc); end
      n_cmp++; if (done_c != last_run_c + 1) begin n_bad++; $display("FAIL dflt_done_latency: got %0d expected %0d", done_c, last_run_c + 1); end
      clear_q();
   endtask

   task automatic test_back_pressure();
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; do_reset(); clear_q();
         start_seq(2, 0, 3);
         run_seq(300, 5, 0);
         n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_stable[%0d]: got %0d changes expected 0", s, unstable); end
         n_cmp++; if (got_addr.size() != 3) begin n_bad++; $display("FAIL bp_words[%0d]: got %0d expected 3", s, got_addr.size()); end
         n_cmp++; if (valid_cyc != 18) begin n_bad++; $display("FAIL bp_valid_cycles[%0d]: got %0d expected 18", s, valid_cyc); end
         while (exp_addr.size() > 0 && got_addr.size() > 0) begin
            logic [ADDR_W-1:0] ea, ga; logic [N-1:0] ed, gd;
            ea = exp_addr.pop_front(); ed = exp_data.pop_front();
            ga = got_addr.pop_front(); gd = got_data.pop_front();
            n_cmp++;
            if ({ga, gd} !== {ea, ed}) begin
               n_bad++; $display("FAIL bp_word[%0d]: got %0d/%h expected %0d/%h", s, ga, gd, ea, ed);
            end
         end
         clear_q();
      end
   endtask

   task automatic test_back_to_back();
      sel = 1'b1; do_reset(); clear_q();
      start_seq(2, 10, 16);
      run_seq(300, 0, 0);
      n_cmp++; if (rst_cyc != 0) begin n_bad++; $display("FAIL b2b_rst_cycles: got %0d expected 0", rst_cyc); end
      n_cmp++; if (run_cyc != 2) begin n_bad++; $display("FAIL b2b_run_cycles: got %0d expected 2", run_cyc); end
      n_cmp++; if (got_addr.size() != 6) begin n_bad++; $display("FAIL b2b_words: got %0d expected 6", got_addr.size()); end
      n_cmp++; if (hs_last - hs_first != 10) begin n_bad++; $display("FAIL b2b_throughput: got %0d expected 10", hs_last - hs_first); end
      while (exp_addr.size() > 0 && got_addr.size() > 0) begin
         logic [ADDR_W-1:0] ea, ga; logic [N-1:0] ed, gd;
         ea = exp_addr.pop_front(); ed = exp_data.pop_front();
         ga = got_addr.pop_front(); gd = got_data.pop_front();
         n_cmp++;
         if ({ga, gd} !== {ea, ed}) begin
            n_bad++; $display("FAIL b2b_word: got %0d/%h expected %0d/%h", ga, gd, ea, ed);
         end
      end
      clear_q();
   endtask

   task automatic test_mid_reset();
      logic seen;
      int vcnt;
      sel = 1'b0; do_reset(); clear_q();
      // start during RUN is ignored: the 50-cycle budget stands
      start_seq(50, 0, 0);
      repeat (10) tick();
      num_cycles = 3; start = 1'b1; tick(); start = 1'b0;
      run_seq(200, 0, 0);
      n_cmp++; if (o_cc !== 32'd50) begin n_bad++; $display("FAIL start_ignored: got %0d expected 50", o_cc); end
      // reset during RUN
      start_seq(50, 0, 4); clear_q();
      repeat (10) tick();
      rst = 1'b1; tick();
      n_cmp++;
      if ({o_core_rst, o_core_run, o_valid, o_done, o_halted, o_cc, o_addr, o_data} !== {5'b10000, 96'd0}) begin
         n_bad++; $display("FAIL rst_in_run: ctrl=%b cc=%0d addr=%0d data=%h expected 10000/0/0/0",
                           {o_core_rst, o_core_run, o_valid, o_done, o_halted}, o_cc, o_addr, o_data);
      end
      rst = 1'b0;
      // reset while a word is waiting in DUMP_OUT
      start_seq(3, 0, 4); clear_q();
      dump_ready = 1'b0; seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         if (o_valid) seen = 1'b1; else tick();
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_dump_reach: got %0b expected 1", seen); end
      rst = 1'b1; tick();
      n_cmp++;
      if ({o_core_rst, o_core_run, o_valid, o_done, o_halted, o_cc, o_mem_addr, o_addr, o_data} !== {5'b10000, 128'd0}) begin
         n_bad++; $display("FAIL rst_in_dump: ctrl=%b cc=%0d addr=%0d data=%h expected 10000/0/0/0",
                           {o_core_rst, o_core_run, o_valid, o_done, o_halted}, o_cc, o_addr, o_data);
      end
      rst = 1'b0; dump_ready = 1'b1; vcnt = 0;
      repeat (8) begin tick(); if (o_valid || o_done) vcnt++; end
      dump_ready = 1'b0;
      n_cmp++; if (vcnt != 0) begin n_bad++; $display("FAIL rst_no_output: got %0d cycles expected 0", vcnt); end
   endtask

   task automatic test_restart();
      sel = 1'b0; do_reset(); clear_q();
      start_seq(4, 1, 3);
      run_seq(200, 0, 0);
      n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL rs_first_done: got %0b expected 1", o_done); end
      clear_q();
      start_seq(3, 5, 5);
      n_cmp++; if ({o_done, o_cc} !== {1'b0, 32'd0}) begin n_bad++; $display("FAIL rs_cleared: done=%0b cc=%0d expected 0/0", o_done, o_cc); end
      run_seq(200, 0, 0);
      n_cmp++; if (run_cyc != 3) begin n_bad++; $display("FAIL rs_run_cycles: got %0d expected 3", run_cyc); end
      n_cmp++; if ({o_done, o_cc} !== {1'b1, 32'd3}) begin n_bad++; $display("FAIL rs_final: done=%0b cc=%0d expected 1/3", o_done, o_cc); end
      clear_q();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
      sel = 1'b0; rst = 1'b1; start = 1'b0; halt_req = 1'b0; dump_ready = 1'b0;
      num_cycles = '0; dump_start = '0; dump_stop = '0;
      test_reset();
      test_nominal();
      test_early_halt();
      test_default_budget();
      test_back_pressure();
      test_back_to_back();
      test_mid_reset();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Synthesizable run and dump sequencer for the multicycle MIPS core. It replaces hard-coded bench sequencing with a parametrised block.
- Sequence: hold the core in reset for a programmable number of cycles, then run it for a cycle budget or until an early-halt request, then read a data-memory window word by word.
- Memory words stream out over a valid/ready port.
- Sits between the host/bench, the core's reset and enable inputs, and a spare read port of the dual-port memory.

Parameters:
N, 32, data word width
ADDR_W, 32, memory word-index width
CYC_W, 32, cycle counter width
RESET_CYCLES, 2, cycles core_rst is held after start (0 allowed)
MAX_CYCLES, 1000, run budget used when num_cycles==0
MEM_LAT, 1, memory read latency in cycles (0 or 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a sequence
num_cycles  in  CYC_W  run budget; 0 selects MAX_CYCLES
dump_start  in  ADDR_W  first word index to dump (inclusive)
dump_stop  in  ADDR_W  last word index bound (exclusive)
halt_req  in  1  early stop request from core/monitor
core_rst  out  1  reset to MIPS core
core_run  out  1  clock-enable to MIPS core
cycle_count  out  CYC_W  run cycles elapsed
mem_rd_addr  out  ADDR_W  read address to memory port
mem_rd_data  in  N  read data from memory port
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word
dump_addr  out  ADDR_W  index of current dump word
dump_data  out  N  current dump word
done  out  1  sequence complete
halted_early  out  1  run ended by halt_req before budget

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state: state=IDLE, core_rst=1, core_run=0, cycle_count=0, mem_rd_addr=0, dump_valid=0, dump_addr=0, dump_data=0, done=0, halted_early=0. Reset mid-run or mid-dump aborts with no further dump output.
- States: IDLE, RESET, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE.
- IDLE / DONE, start=1:
  - Latch budget = (num_cycles==0 ? MAX_CYCLES : num_cycles).
  - Latch dump_start and dump_stop.
  - Clear done, halted_early and cycle_count.
  - Go to RESET.
  - start in any other state is ignored.
- RESET: core_rst=1, core_run=0 for exactly RESET_CYCLES cycles, then RUN. With RESET_CYCLES=0, go to RUN on the cycle after start.
- RUN:
  - core_rst=0, core_run=1, cycle_count increments by 1 each cycle.
  - Exit after the cycle in which cycle_count becomes budget, or on any cycle halt_req=1.
  - halted_early=1 only if halt_req=1 and cycle_count+1 < budget. If halt_req coincides with budget reached, halted_early=0.
  - On exit: core_run=0 and core_rst stays 0, so the core is frozen and its state is preserved.
  - cycle_count holds its final value until the next start or rst.
- Dump entry:
  - If dump_stop <= dump_start (unsigned), go directly to DONE with no words.
  - Otherwise dump_addr = dump_start, go to DUMP_ADDR.
- DUMP_ADDR: drive mem_rd_addr = dump_addr.
  - MEM_LAT=1: go to DUMP_WAIT.
  - MEM_LAT=0: capture mem_rd_data the same cycle and go to DUMP_OUT.
- DUMP_WAIT: capture mem_rd_data into dump_data, go to DUMP_OUT.
- DUMP_OUT:
  - dump_valid=1. dump_data and dump_addr are stable until the handshake (dump_valid & dump_ready at a clock edge).
  - On handshake: dump_valid=0 next cycle.
  - If dump_addr+1 == dump_stop, go to DONE. Otherwise dump_addr += 1 and go to DUMP_ADDR.
  - Back-pressure of any length is allowed.
- DONE: done=1, core_run=0, core_rst=0. Held until rst, or until start restarts the sequence.
- Throughput is one word per 3 cycles (MEM_LAT=1) or 2 cycles (MEM_LAT=0) with dump_ready tied high.
- All counters are unsigned and wrap modulo their width. dump_stop is exclusive, so the window never wraps.

Test Plan:
- Nominal run: RESET_CYCLES=2, start with num_cycles=5, dump 4..14, dump_ready=1, halt_req=0 -> core_rst high 2 cycles, core_run high exactly 5 cycles, cycle_count=5, then 10 handshakes with dump_addr 4..13 whose dump_data matches preloaded DMEM[4..13], then done=1, halted_early=0.
- Early halt: num_cycles=100, halt_req pulsed on run cycle 7 -> core_run drops next cycle, cycle_count=7, halted_early=1, dump proceeds. Repeat with halt_req on cycle 100 of budget 100 -> halted_early=0.
- Default budget and empty window: num_cycles=0, dump_start=dump_stop=8 -> run lasts MAX_CYCLES=1000 cycles, no dump_valid, done=1 the cycle after the run ends.
- Back-pressure: dump 0..3 with dump_ready low for 5 cycles on each word -> dump_data/dump_addr stable while valid, exactly 3 words delivered in order, no duplicates or drops. Repeat with MEM_LAT=0.
- Mid-operation reset and restart: rst asserted during RUN, then during DUMP_OUT -> all outputs at reset values next cycle. start ignored in RUN. A new start from DONE with num_cycles=3 -> done cleared, new 3-cycle run, cycle_count restarts at 0.
